// File: rtl/delay_gen_pkg.sv
// Shared types and default sizing for the delay_gen programmable delay generator.
package delay_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_FIRE  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MLT_X1  = 2'd0,
        MLT_MID = 2'd1,
        MLT_HI  = 2'd2,
        MLT_HI2 = 2'd3
    } mlt_t;

    localparam int DEF_CNT_W   = 17;
    localparam int DEF_MID_DIV = 100;
    localparam int DEF_HI_DIV  = 100000;
    localparam int DEF_REP_W   = 8;

    // Prescale width large enough to hold the larger divider value.
    function automatic int div_width(input int mid_div, input int hi_div);
        int big;
        big = (hi_div > mid_div) ? hi_div : mid_div;
        return $clog2(big + 1);
    endfunction

endpackage

// File: rtl/dg_prescaler.sv
// Base counter (0..limit-1) cascaded into a prescale counter (0..div-1);
// tc flags the base wrap on which the prescaler is at its last step.
module dg_prescaler #(
    parameter int CNT_W = 17,
    parameter int DIV_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    input  logic [DIV_W-1:0] div,
    output logic             tc
);

    logic [CNT_W-1:0] base_cnt;
    logic [DIV_W-1:0] pre_cnt;
    logic             base_last;
    logic             pre_last;

    assign base_last = (base_cnt == limit - CNT_W'(1));
    assign pre_last  = (pre_cnt == div - DIV_W'(1));
    assign tc        = en && base_last && pre_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_cnt <= '0;
            pre_cnt  <= '0;
        end else if (clr) begin
            base_cnt <= '0;
            pre_cnt  <= '0;
        end else if (en) begin
            if (base_last) begin
                base_cnt <= '0;
                pre_cnt  <= pre_last ? '0 : pre_cnt + DIV_W'(1);
            end else begin
                base_cnt <= base_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/delay_gen.sv
// Launch-triggered delay generator: repeats delay*DIV cycle windows, pulsing
// launch_pl at each expiry and holding end_flg until the request is released.
module delay_gen
    import delay_gen_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MID_DIV = DEF_MID_DIV,
    parameter int HI_DIV  = DEF_HI_DIV,
    parameter int REP_W   = DEF_REP_W
) (
    input  logic             clk_delay_gen,
    input  logic             rst,
    input  logic             dl_launch,
    input  logic [CNT_W-1:0] delay,
    input  logic [1:0]       dl_mlt,
    input  logic [REP_W-1:0] repeat_num,
    output logic             dl_out,
    output logic             launch_pl,
    output logic             end_flg,
    output logic             busy,
    output logic             err
);

    localparam int DIV_W = div_width(MID_DIV, HI_DIV);

    state_t           state, state_next;
    logic             launch_q;
    logic             launch_edge;
    logic             accept;
    logic             reject;
    logic             tc;
    logic [CNT_W-1:0] delay_l;
    mlt_t             mlt_l;
    logic [REP_W-1:0] rep_l;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_target;
    logic [DIV_W-1:0] div_sel;

    assign launch_edge = dl_launch && !launch_q;
    assign rep_target  = (rep_l == '0) ? REP_W'(1) : rep_l;

    always_comb begin
        div_sel = DIV_W'(HI_DIV);
        case (mlt_l)
            MLT_X1:  div_sel = DIV_W'(1);
            MLT_MID: div_sel = DIV_W'(MID_DIV);
            default: div_sel = DIV_W'(HI_DIV);
        endcase
    end

    dg_prescaler #(
        .CNT_W(CNT_W),
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk  (clk_delay_gen),
        .rst  (rst),
        .clr  (state != ST_DELAY),
        .en   (state == ST_DELAY),
        .limit(delay_l),
        .div  (div_sel),
        .tc   (tc)
    );

    // Abort (dl_launch low) is tested before expiry so it wins a tie.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (launch_edge) begin
                    if (delay != '0) begin
                        accept     = 1'b1;
                        state_next = ST_DELAY;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_DELAY: begin
                if (!dl_launch)  state_next = ST_IDLE;
                else if (tc)     state_next = ST_FIRE;
            end
            ST_FIRE: begin
                if (!dl_launch)                  state_next = ST_IDLE;
                else if (rep_cnt == rep_target)  state_next = ST_DONE;
                else                             state_next = ST_DELAY;
            end
            ST_DONE: begin
                if (!dl_launch) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_delay_gen or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            launch_q  <= 1'b0;
            delay_l   <= '0;
            mlt_l     <= MLT_X1;
            rep_l     <= '0;
            rep_cnt   <= '0;
            dl_out    <= 1'b0;
            launch_pl <= 1'b0;
            end_flg   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state    <= state_next;
            launch_q <= dl_launch;
            if (accept) begin
                delay_l <= delay;
                mlt_l   <= mlt_t'(dl_mlt);
                rep_l   <= repeat_num;
                rep_cnt <= '0;
            end else if (state == ST_DELAY && state_next == ST_FIRE) begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
            // Outputs decode the next state so they are registered yet aligned with it.
            dl_out    <= (state_next == ST_DELAY);
            launch_pl <= (state_next == ST_FIRE);
            end_flg   <= (state_next == ST_DONE);
            busy      <= (state_next == ST_DELAY) || (state_next == ST_FIRE);
            err       <= reject;
        end
    end

endmodule

// File: tb/tb_delay_gen.sv
// Directed self-checking bench for delay_gen with default parameters.
module tb_delay_gen;

    logic        clk_delay_gen = 1'b0;
    logic        rst;
    logic        dl_launch;
    logic [16:0] delay;
    logic [1:0]  dl_mlt;
    logic [7:0]  repeat_num;
    logic        dl_out;
    logic        launch_pl;
    logic        end_flg;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    delay_gen #(
        .CNT_W  (17),
        .MID_DIV(100),
        .HI_DIV (100000),
        .REP_W  (8)
    ) dut (
        .clk_delay_gen(clk_delay_gen),
        .rst          (rst),
        .dl_launch    (dl_launch),
        .delay        (delay),
        .dl_mlt       (dl_mlt),
        .repeat_num   (repeat_num),
        .dl_out       (dl_out),
        .launch_pl    (launch_pl),
        .end_flg      (end_flg),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk_delay_gen = ~clk_delay_gen;

    task automatic tick();
        @(posedge clk_delay_gen);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [4:0] exp);
        check(tag, {dl_out, launch_pl, end_flg, busy, err}, {27'd0, exp});
    endtask

    // Single window of d cycles at x1; inputs are disturbed mid-window.
    task automatic single_x1(input string tag, input logic [16:0] d, input logic [7:0] r);
        delay = d; dl_mlt = 2'd0; repeat_num = r; dl_launch = 1'b1;
        for (int i = 1; i <= int'(d); i++) begin
            tick();
            if (i == 1) begin
                delay = 17'd2; dl_mlt = 2'd1; repeat_num = 8'd5;
            end
            check_outs({tag, "_win"}, 5'b10010);
        end
        tick();
        check_outs({tag, "_fire"}, 5'b01010);
        tick();
        check_outs({tag, "_done"}, 5'b00100);
        tick(); tick();
        check_outs({tag, "_hold"}, 5'b00100);
        dl_launch = 1'b0;
        tick();
        check_outs({tag, "_release"}, 5'b00000);
    endtask

    initial begin
        int cnt;
        int seen_pl;

        rst = 1'b1; dl_launch = 1'b0; delay = '0; dl_mlt = '0; repeat_num = '0;
        tick(); tick();
        check_outs("reset", 5'b00000);
        rst = 1'b0;
        tick();
        check_outs("idle", 5'b00000);

        single_x1("t1", 17'd5, 8'd1);

        // x MID_DIV window
        delay = 17'd3; dl_mlt = 2'd1; repeat_num = 8'd1; dl_launch = 1'b1;
        tick();
        cnt = 0;
        while (dl_out && cnt < 400) begin
            cnt++;
            tick();
        end
        check("t2_len", cnt, 300);
        check_outs("t2_fire", 5'b01010);
        tick();
        check_outs("t2_done", 5'b00100);
        dl_launch = 1'b0;
        tick();

        // three windows
        delay = 17'd4; dl_mlt = 2'd0; repeat_num = 8'd3; dl_launch = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                check_outs("t3_win", 5'b10010);
            end
            tick();
            check_outs("t3_fire", 5'b01010);
        end
        tick();
        check_outs("t3_done", 5'b00100);
        dl_launch = 1'b0;
        tick();
        check_outs("t3_release", 5'b00000);

        // abort at cycle 3, then relaunch with repeat 0 (acts as 1)
        delay = 17'd10; dl_mlt = 2'd0; repeat_num = 8'd1; dl_launch = 1'b1;
        tick(); tick();
        check_outs("t4_run", 5'b10010);
        dl_launch = 1'b0;
        tick();
        check_outs("t4_abort", 5'b00000);
        seen_pl = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (launch_pl || end_flg || dl_out) seen_pl++;
        end
        check("t4_quiet", seen_pl, 0);
        single_x1("t4_relaunch", 17'd5, 8'd0);

        // abort coinciding with expiry
        delay = 17'd4; dl_mlt = 2'd0; repeat_num = 8'd1; dl_launch = 1'b1;
        tick(); tick(); tick(); tick();
        check_outs("t5_last", 5'b10010);
        dl_launch = 1'b0;
        tick();
        check_outs("t5_abort_wins", 5'b00000);
        tick();

        // zero delay is rejected
        delay = 17'd0; dl_launch = 1'b1;
        tick();
        check_outs("t6_err", 5'b00001);
        tick();
        check_outs("t6_err_clear", 5'b00000);
        dl_launch = 1'b0;
        tick();

        // reset mid-window, then a held launch restarts after release
        delay = 17'd20; dl_mlt = 2'd0; repeat_num = 8'd1; dl_launch = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_outs("t7_run", 5'b10010);
        #2 rst = 1'b1;
        #1;
        check_outs("t7_async_rst", 5'b00000);
        tick(); tick();
        check_outs("t7_in_rst", 5'b00000);
        rst = 1'b0;
        cnt = 0;
        seen_pl = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dl_out) cnt++;
            if (launch_pl) seen_pl++;
        end
        check("t7_restart_len", cnt, 20);
        check("t7_no_early_pl", seen_pl, 0);
        tick();
        check_outs("t7_fire", 5'b01010);
        dl_launch = 1'b0;
        tick();

        // x HI_DIV: still running well past what x1 or x MID_DIV would give
        delay = 17'd1; dl_mlt = 2'd2; repeat_num = 8'd1; dl_launch = 1'b1;
        seen_pl = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (launch_pl || !dl_out) seen_pl++;
        end
        check("t8_hi_running", seen_pl, 0);
        dl_launch = 1'b0;
        tick();
        check_outs("t8_abort", 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_gen.md
DELAY_GEN -- requirements
Module: delay_gen

Interface
REQ-001 The parameter list SHALL be:
- CNT_W, default 17, width of the base delay count.
- MID_DIV, default 100, multiplier for mode 1.
- HI_DIV, default 100000, multiplier for modes 2 and 3.
- REP_W, default 8, width of the repeat count.
REQ-002 The port list SHALL be (name, direction, width, meaning):
- clk_delay_gen, in, 1, sole clock, rising-edge.
- rst, in, 1, asynchronous active-high reset.
- dl_launch, in, 1, level request; a rising edge starts, a low level aborts or releases.
- delay, in, CNT_W, base delay in clock cycles.
- dl_mlt, in, 2, multiplier select: 0 = x1, 1 = xMID_DIV, 2 or 3 = xHI_DIV.
- repeat, in, REP_W, number of delay windows; 0 is treated as 1.
- dl_out, out, 1, high while a delay window runs.
- launch_pl, out, 1, one-cycle pulse at each window expiry.
- end_flg, out, 1, sequence complete; held high until dl_launch goes low.
- busy, out, 1, high in DELAY or FIRE.
- err, out, 1, one-cycle pulse when a launch is rejected.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, DELAY, FIRE, DONE.
REQ-004 The block SHALL register dl_launch internally (one flop), and a launch edge SHALL be defined as dl_launch = 1 with the registered copy = 0.
REQ-005 In IDLE, a launch edge with delay != 0 SHALL latch delay, dl_mlt and repeat, clear all counters, and enter DELAY on the next edge.
REQ-006 In IDLE, a launch edge with delay == 0 SHALL pulse err for one cycle, and the FSM SHALL remain in IDLE.
REQ-007 Input changes after the latch SHALL have no effect until the next launch edge.
REQ-008 In DELAY, the base counter SHALL count 0..delay-1 and then wrap to 0.
REQ-009 Each base-counter wrap SHALL increment a prescale counter, which counts 0..DIV-1, where DIV is 1, MID_DIV or HI_DIV according to the latched dl_mlt.
REQ-010 Expiry SHALL occur on the base wrap at which the prescale counter equals DIV-1, so each window lasts exactly delay*DIV cycles.
REQ-011 dl_out SHALL be 1 throughout DELAY and 0 in every other state.
REQ-012 On expiry the FSM SHALL enter FIRE for exactly one cycle, in which launch_pl = 1 and the repeat counter increments.
REQ-013 From FIRE the FSM SHALL go to DONE if the repeat counter equals max(repeat,1); otherwise it SHALL return to DELAY with the base and prescale counters cleared.
REQ-014 The gap between consecutive windows SHALL therefore be exactly one cycle.
REQ-015 In DONE, end_flg SHALL be 1; when dl_launch is low the FSM SHALL go to IDLE and end_flg SHALL clear on the same edge.
REQ-016 dl_launch low while in DELAY or FIRE SHALL abort to IDLE on the next edge: dl_out = 0, no launch_pl pulse, end_flg unchanged at 0.
REQ-017 If abort and expiry coincide in the same cycle, abort SHALL win.
REQ-018 Counters SHALL be sized to the parameters (HI_DIV requires 17 bits), SHALL never overflow, and SHALL never wrap past their terminal values.
REQ-019 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-020 rst = 1 SHALL asynchronously force state IDLE, all counters and latched inputs to 0, and the registered dl_launch to 0.
REQ-021 Output reset values SHALL be: dl_out 0, launch_pl 0, end_flg 0, busy 0, err 0.
REQ-022 Reset mid-sequence SHALL terminate the sequence with no launch_pl pulse.
REQ-023 After rst deasserts, a dl_launch that is already high SHALL count as a launch edge.

Structure
REQ-024 The package delay_gen_pkg SHALL hold the state enum, the dl_mlt mode codes, and the default CNT_W, MID_DIV, HI_DIV and REP_W values.
REQ-025 The base and prescale counters SHALL be implemented as one sub-module, dg_prescaler, which has clear and enable inputs and a terminal-count output; the FSM, repeat counter and outputs SHALL stay in delay_gen.

Verification (MID_DIV = 100, launch edge registered at cycle 0)
REQ-026 delay=5, dl_mlt=0, repeat=1 -> dl_out high cycles 1-5, launch_pl at cycle 6, end_flg from cycle 7 until dl_launch falls.
REQ-027 delay=3, dl_mlt=1, repeat=1 -> dl_out high for exactly 300 cycles, followed by one launch_pl pulse.
REQ-028 delay=4, dl_mlt=0, repeat=3 -> three 4-cycle dl_out windows separated by 1-cycle launch_pl pulses (3 pulses in total), with end_flg set only after the third.
REQ-029 delay=10, dl_mlt=0, with dl_launch dropped at cycle 3 -> IDLE, dl_out low from cycle 4, no launch_pl, end_flg 0; a relaunch then behaves as in REQ-026.
REQ-030 delay=0 launch -> one err pulse, busy stays 0; rst pulsed mid-window with delay=20 -> all outputs 0 immediately and no launch_pl.
